// File: rtl/byte_unstripping_nlane_pkg.sv
// Shared helpers for the N-lane byte unstripper: a ceil-log2 for sizing
// pointers and counters, and a macro that picks one lane out of the flat
// lane bus (lane i lives in bits [i*width +: width]).

`ifndef BYTE_UNSTRIPPING_NLANE_MACROS
`define BYTE_UNSTRIPPING_NLANE_MACROS
`define LANE_SLICE(bus, idx, width) bus[(idx)*(width) +: (width)]
`endif

package byte_unstripping_nlane_pkg;

  // Smallest minimum number of lanes / FIFO entries the datapath is sized for.
  localparam int MIN_LANES      = 2;
  localparam int MIN_FIFO_DEPTH = 2;

  // Ceil-log2 usable in constant expressions; values <= 1 give 0, so callers
  // only use it on quantities of at least 2.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/unstripe_lane_fifo.sv
// Per-lane elastic FIFO. Absorbs inter-lane skew and bursty lane valids.
// A push into a full FIFO is still accepted when the same FIFO is popped in
// that cycle; otherwise the word is dropped and the sticky overflow flag set.
// The full flag is registered so it reflects the occupancy after the edge.

module unstripe_lane_fifo
  import byte_unstripping_nlane_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_f,
  input  logic                  reset,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  empty,
  output logic                  full,
  output logic                  overflow
);

  localparam int PTR_W = clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [CNT_W-1:0]      r_count;
  logic [CNT_W-1:0]      w_countNext;
  logic                  r_full;
  logic                  r_overflow;
  logic                  w_isFull;
  logic                  w_doPop;
  logic                  w_doPush;
  logic                  w_drop;

  // A pop frees a slot in the same cycle, which is what lets a full FIFO
  // accept a simultaneous push without losing data.
  assign w_isFull = (r_count == DEPTH_CNT);
  assign w_doPop  = pop && (r_count != '0);
  assign w_doPush = push && (!w_isFull || w_doPop);
  assign w_drop   = push && !w_doPush;

  // Occupancy after this edge; push and pop together leave it unchanged.
  always_comb begin
    w_countNext = r_count;
    case ({w_doPush, w_doPop})
      2'b10:   w_countNext = r_count + CNT_W'(1);
      2'b01:   w_countNext = r_count - CNT_W'(1);
      default: w_countNext = r_count;
    endcase
  end

  // Storage array; no reset needed since the pointers define what is valid.
  always_ff @(posedge clk_f) begin
    if (w_doPush) begin
      r_mem[r_wrPtr] <= din;
    end
  end

  // Pointers wrap naturally at FIFO_DEPTH (power of two); count, full and the
  // sticky overflow flag are all flushed by reset.
  always_ff @(posedge clk_f) begin
    if (reset) begin
      r_wrPtr    <= '0;
      r_rdPtr    <= '0;
      r_count    <= '0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_doPush) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_doPop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
      r_count <= w_countNext;
      r_full  <= (w_countNext == DEPTH_CNT);
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign dout     = r_mem[r_rdPtr];
  assign empty    = (r_count == '0);
  assign full     = r_full;
  assign overflow = r_overflow;

endmodule

// File: rtl/byte_unstripping_nlane.sv
// N-lane byte unstripper. Each lane feeds its own elastic FIFO; a round-robin
// read pointer pulls one word per cycle from lane 0, 1, ..., NUM_LANES-1 in
// turn and loads it into a registered output with a valid/ready handshake.
// The pointer never skips an empty lane, so a lagging lane stalls the output
// until its word arrives and the original byte order is preserved.

module byte_unstripping_nlane
  import byte_unstripping_nlane_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_LANES  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                            clk_f,
  input  logic                            reset,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] data_lane_in,
  input  logic [NUM_LANES-1:0]            valid_lane_in,
  input  logic                            ready_out,
  output logic [DATA_WIDTH-1:0]           data_unstripe_out,
  output logic                            valid_unstripe_out,
  output logic [NUM_LANES-1:0]            lane_full,
  output logic [NUM_LANES-1:0]            lane_overflow,
  output logic [clog2(NUM_LANES)-1:0]     rd_lane
);

  localparam int LANE_W = clog2(NUM_LANES);
  localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(NUM_LANES - 1);

  logic [DATA_WIDTH-1:0] w_laneHead [NUM_LANES];
  logic [NUM_LANES-1:0]  w_laneEmpty;
  logic [NUM_LANES-1:0]  w_pop;
  logic [DATA_WIDTH-1:0] w_headWord;
  logic                  w_outFree;
  logic                  w_load;
  logic [LANE_W-1:0]     w_rdLaneNext;
  logic [LANE_W-1:0]     r_rdLane;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;

  // One FIFO per lane; only the lane under the read pointer is ever popped.
  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      assign w_pop[gi] = w_load && (r_rdLane == LANE_W'(gi));

      unstripe_lane_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
      ) u_laneFifo (
        .clk_f    (clk_f),
        .reset    (reset),
        .push     (valid_lane_in[gi]),
        .din      (`LANE_SLICE(data_lane_in, gi, DATA_WIDTH)),
        .pop      (w_pop[gi]),
        .dout     (w_laneHead[gi]),
        .empty    (w_laneEmpty[gi]),
        .full     (lane_full[gi]),
        .overflow (lane_overflow[gi])
      );
    end
  endgenerate

  // The output register can take a new word when it is empty or being
  // drained this cycle, and only if the current lane has something queued.
  assign w_headWord = w_laneHead[r_rdLane];
  assign w_outFree  = !r_valid || ready_out;
  assign w_load     = w_outFree && !w_laneEmpty[r_rdLane];

  // Explicit wrap because NUM_LANES need not be a power of two.
  assign w_rdLaneNext = (r_rdLane == LAST_LANE) ? '0 : r_rdLane + LANE_W'(1);

  // Output register and round-robin pointer: load and advance together,
  // drop valid once consumed with nothing to follow, otherwise hold.
  always_ff @(posedge clk_f) begin
    if (reset) begin
      r_data   <= '0;
      r_valid  <= 1'b0;
      r_rdLane <= '0;
    end else if (w_load) begin
      r_data   <= w_headWord;
      r_valid  <= 1'b1;
      r_rdLane <= w_rdLaneNext;
    end else if (ready_out) begin
      r_valid  <= 1'b0;
    end
  end

  assign data_unstripe_out  = r_data;
  assign valid_unstripe_out = r_valid;
  assign rd_lane            = r_rdLane;

endmodule
